// File: rtl/nfu2_accum_sched.sv
// nfu2_accum_sched: NFU-2 sequencer and Tn-lane partial-sum accumulator.
// Ports: clk, rst_n (async low); i_start/i_num_tiles/i_clear control;
//   i_sum/i_sum_valid/o_sum_ready beat input; o_tile_idx read index;
//   o_res/o_res_valid/i_res_ready result output; o_busy status.
// Build option: define NFU2_ACC_SAT_EN for saturating lane adds
//   (default build wraps modulo 2^N).
module nfu2_accum_sched #(
    parameter int N     = 16,
    parameter int Tn    = 16,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_tiles,
    input  logic              i_clear,
    input  logic [Tn*N-1:0]   i_sum,
    input  logic              i_sum_valid,
    output logic              o_sum_ready,
    output logic [CNT_W-1:0]  o_tile_idx,
    output logic [Tn*N-1:0]   o_res,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_tiles;
    logic [Tn*N-1:0]    acc;
    logic [Tn*N-1:0]    acc_nxt;
    logic               last_beat;

    function automatic logic [N-1:0] lane_add(
        input logic [N-1:0] a,
        input logic [N-1:0] b
    );
`ifdef NFU2_ACC_SAT_EN
        logic [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        // Sign bits disagree only when the N-bit result overflowed.
        if (s[N] != s[N-1]) begin
            lane_add = s[N] ? {1'b1, {(N-1){1'b0}}}
                            : {1'b0, {(N-1){1'b1}}};
        end else begin
            lane_add = s[N-1:0];
        end
`else
        lane_add = a + b;
`endif
    endfunction

    always_comb begin
        acc_nxt = acc;
        for (int j = 0; j < Tn; j++) begin
            acc_nxt[j*N +: N] = lane_add(acc[j*N +: N], i_sum[j*N +: N]);
        end
    end

    assign last_beat   = (o_tile_idx == num_tiles - CNT_W'(1));
    assign o_sum_ready = (state == S_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            num_tiles   <= '0;
            acc         <= '0;
            o_tile_idx  <= '0;
            o_res       <= '0;
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else if (i_clear) begin
            state       <= S_IDLE;
            num_tiles   <= '0;
            acc         <= '0;
            o_tile_idx  <= '0;
            o_res       <= '0;
            o_res_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        num_tiles  <= (i_num_tiles == '0) ? CNT_W'(1)
                                                          : i_num_tiles;
                        acc        <= '0;
                        o_tile_idx <= '0;
                        o_busy     <= 1'b1;
                        state      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_sum_valid) begin
                        acc        <= acc_nxt;
                        o_tile_idx <= o_tile_idx + CNT_W'(1);
                        if (last_beat) begin
                            o_res       <= acc_nxt;
                            o_res_valid <= 1'b1;
                            state       <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nfu2_accum_sched.sv
// tb_nfu2_accum_sched: randomized + directed bench for nfu2_accum_sched.
// Expected results come from an integer lane-sum model in the bench.
module tb_nfu2_accum_sched;

    localparam int N     = 16;
    localparam int Tn    = 16;
    localparam int CNT_W = 8;
    localparam int W     = Tn * N;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_num_tiles;
    logic             i_clear;
    logic [W-1:0]     i_sum;
    logic             i_sum_valid;
    logic             o_sum_ready;
    logic [CNT_W-1:0] o_tile_idx;
    logic [W-1:0]     o_res;
    logic             o_res_valid;
    logic             i_res_ready;
    logic             o_busy;

    int n_chk;
    int n_pass;
    logic [W-1:0] tq[$];

    nfu2_accum_sched #(
        .N(N),
        .Tn(Tn),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_num_tiles(i_num_tiles),
        .i_clear(i_clear),
        .i_sum(i_sum),
        .i_sum_valid(i_sum_valid),
        .o_sum_ready(o_sum_ready),
        .o_tile_idx(o_tile_idx),
        .o_res(o_res),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(
        input string        tag,
        input logic [W-1:0] got,
        input logic [W-1:0] exp
    );
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] fill(input logic [N-1:0] v);
        logic [W-1:0] r;
        for (int j = 0; j < Tn; j++) r[j*N +: N] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] r;
        for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int ref_add(input int a, input int b);
        int s;
        s = a + b;
`ifdef NFU2_ACC_SAT_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`else
        s = ((s % 65536) + 65536 + 32768) % 65536 - 32768;
`endif
        return s;
    endfunction

    // Expected group result from the tiles queued in tq.
    function automatic logic [W-1:0] model_res();
        int lane [Tn];
        logic [W-1:0] r;
        logic [W-1:0] t;
        logic signed [N-1:0] x;
        for (int j = 0; j < Tn; j++) lane[j] = 0;
        foreach (tq[k]) begin
            t = tq[k];
            for (int j = 0; j < Tn; j++) begin
                x = t[j*N +: N];
                lane[j] = ref_add(lane[j], int'(x));
            end
        end
        for (int j = 0; j < Tn; j++) r[j*N +: N] = N'(lane[j]);
        return r;
    endfunction

    task automatic run_group(
        input int n,
        input int gap_max,
        input int bp_min,
        input int bp_max,
        input bit noisy_start
    );
        logic [W-1:0] exp;
        int beats;
        int gaps;
        int bp;
        beats = (n == 0) ? 1 : n;
        exp = model_res();
        i_start = 1'b1;
        i_num_tiles = CNT_W'(n);
        tick();
        i_start = 1'b0;
        check("start_busy", W'(o_busy), W'(1));
        check("start_ready", W'(o_sum_ready), W'(1));
        for (int t = 0; t < beats; t++) begin
            gaps = $urandom_range(gap_max, 0);
            for (int g = 0; g < gaps; g++) begin
                i_sum_valid = 1'b0;
                i_sum = rnd_vec();
                tick();
                check("stall_ready", W'(o_sum_ready), W'(1));
            end
            check("tile_idx", W'(o_tile_idx), W'(t));
            i_sum = tq[t];
            i_sum_valid = 1'b1;
            if (noisy_start && t == 0) begin
                i_start = 1'b1;
                i_num_tiles = CNT_W'(9);
            end
            tick();
            i_start = 1'b0;
            i_sum_valid = 1'b0;
            if (t < beats - 1) begin
                check("mid_valid", W'(o_res_valid), W'(0));
            end
        end
        check("res_valid", W'(o_res_valid), W'(1));
        check("res", o_res, exp);
        check("out_ready", W'(o_sum_ready), W'(0));
        bp = $urandom_range(bp_max, bp_min);
        for (int b = 0; b < bp; b++) begin
            i_res_ready = 1'b0;
            i_sum_valid = 1'b1;
            i_sum = rnd_vec();
            tick();
            check("bp_res", o_res, exp);
            check("bp_valid", W'(o_res_valid), W'(1));
            check("bp_ready", W'(o_sum_ready), W'(0));
        end
        i_sum_valid = 1'b0;
        i_res_ready = 1'b1;
        tick();
        i_res_ready = 1'b0;
        check("done_valid", W'(o_res_valid), W'(0));
        check("done_busy", W'(o_busy), W'(0));
        check("done_ready", W'(o_sum_ready), W'(0));
    endtask

    task automatic partial_four();
        i_start = 1'b1;
        i_num_tiles = CNT_W'(4);
        tick();
        i_start = 1'b0;
        for (int t = 0; t < 2; t++) begin
            i_sum = fill(16'd7);
            i_sum_valid = 1'b1;
            tick();
        end
        i_sum_valid = 1'b0;
        check("part_idx", W'(o_tile_idx), W'(2));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, W'(o_sum_ready), W'(0));
        check({tag, "_idx"}, W'(o_tile_idx), W'(0));
        check({tag, "_res"}, o_res, W'(0));
        check({tag, "_valid"}, W'(o_res_valid), W'(0));
        check({tag, "_busy"}, W'(o_busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] v;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        i_start = 1'b0;
        i_num_tiles = '0;
        i_clear = 1'b0;
        i_sum = '0;
        i_sum_valid = 1'b0;
        i_res_ready = 1'b0;
        #12;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        tq = {};
        tq.push_back(fill(16'd1));
        tq.push_back(fill(16'd2));
        tq.push_back(fill(16'd3));
        check("three_model", model_res(), fill(16'd6));
        run_group(3, 0, 0, 0, 1'b0);

        tq = {};
        for (int j = 0; j < Tn; j++) v[j*N +: N] = N'(j);
        tq.push_back(v);
        run_group(0, 0, 0, 0, 1'b0);

        tq = {};
        tq.push_back(rnd_vec());
        tq.push_back(rnd_vec());
        run_group(2, 0, 5, 5, 1'b0);

        tq = {};
        tq.push_back(fill(16'h7000));
        tq.push_back(fill(16'h7000));
`ifdef NFU2_ACC_SAT_EN
        check("ovf_pos_model", model_res(), fill(16'h7FFF));
`else
        check("ovf_pos_model", model_res(), fill(16'hE000));
`endif
        run_group(2, 0, 0, 0, 1'b0);

        tq = {};
        tq.push_back(fill(16'h9000));
        tq.push_back(fill(16'h9000));
`ifdef NFU2_ACC_SAT_EN
        check("ovf_neg_model", model_res(), fill(16'h8000));
`else
        check("ovf_neg_model", model_res(), fill(16'h2000));
`endif
        run_group(2, 0, 0, 0, 1'b0);

        partial_four();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tq = {};
        tq.push_back(fill(16'd5));
        run_group(1, 0, 0, 0, 1'b0);

        partial_four();
        i_clear = 1'b1;
        i_sum = fill(16'd7);
        i_sum_valid = 1'b1;
        tick();
        i_clear = 1'b0;
        i_sum_valid = 1'b0;
        check_zero("clear");
        tq = {};
        tq.push_back(fill(16'd5));
        run_group(1, 0, 0, 0, 1'b0);

        tq = {};
        for (int k = 0; k < 3; k++) tq.push_back(rnd_vec());
        run_group(3, 1, 0, 1, 1'b1);

        for (int g = 0; g < 25; g++) begin
            int n;
            n = $urandom_range(6, 0);
            tq = {};
            for (int k = 0; k < ((n == 0) ? 1 : n); k++) begin
                tq.push_back(rnd_vec());
            end
            run_group(n, 2, 0, 3, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nfu2_accum_sched.md
# nfu2_accum_sched

Sequencer and partial-sum accumulator for the NFU-2 adder-tree cluster. It consumes one Tn-lane vector of adder-tree sums per accepted beat, accumulates a programmed number of input tiles per output group, and presents the finished Tn-lane result to the NFU-3 stage through a valid/ready handshake. It sits directly downstream of the `n1_cluster` adder trees. It also exports the current tile index so upstream buffers can sequence their reads.

## Interface
- `N`, 16: lane width in bits; lanes are two's-complement signed.
- `Tn`, 16: number of lanes, one per adder tree.
- `CNT_W`, 8: width of the tile-count and tile-index fields.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  begins an output group; sampled only in IDLE.
- `i_num_tiles`  in  CNT_W  tiles per group, latched on an accepted start; value 0 is treated as 1.
- `i_clear`  in  1  synchronous abort.
- `i_sum`  in  Tn*N  adder-tree sums; lane j is bits [j*N+N-1 : j*N].
- `i_sum_valid`  in  1  `i_sum` is valid this cycle.
- `o_sum_ready`  out  1  block accepts `i_sum` this cycle.
- `o_tile_idx`  out  CNT_W  index of the next tile to be accepted.
- `o_res`  out  Tn*N  accumulated result; lane layout matches `i_sum`.
- `o_res_valid`  out  1  `o_res` is valid.
- `i_res_ready`  in  1  downstream accepts `o_res`.
- `o_busy`  out  1  block is in ACCUM or OUT.

## Operation
- States: IDLE, ACCUM, OUT. Reset state is IDLE.
- In IDLE:
  - `o_sum_ready`=0, `o_res_valid`=0, `o_busy`=0.
  - On `i_start`=1, latch `i_num_tiles` (0 becomes 1), clear the accumulator and `o_tile_idx`, then go to ACCUM.
- In ACCUM:
  - `o_sum_ready`=1.
  - A beat is accepted when `i_sum_valid` and `o_sum_ready` are both 1.
  - On each accepted beat, for every lane j: acc[j] = acc[j] + i_sum[j], computed at N bits. Then `o_tile_idx` increments.
  - On the beat with `o_tile_idx` == num_tiles-1, the final sum is written to `o_res` and the state goes to OUT.
  - A cycle with `i_sum_valid`=0 stalls with no state change.
- In OUT:
  - `o_res_valid`=1 and `o_sum_ready`=0.
  - `o_res` is held stable until `i_res_ready`=1. On that cycle the result is handed off and the state returns to IDLE.
- `i_start` asserted in ACCUM or OUT is ignored; it is not queued.
- `i_clear`=1 in any state forces IDLE on the next edge: accumulator, index and `o_res` are zeroed and any partial group is discarded. `i_clear` has priority over `i_start` and over beat acceptance in the same cycle.
- Arithmetic: lane sums are signed N-bit. Overflow behaviour is set by the macro described under Configuration.
- `rst_n` low, including mid-group, asynchronously forces IDLE. All registers and outputs go to 0 and the partial group is lost.

## Timing
- Reset values: `o_sum_ready`=0, `o_tile_idx`=0, `o_res`=0, `o_res_valid`=0, `o_busy`=0.
- Start accepted at cycle t gives `o_sum_ready`=1 from t+1.
- Throughput: one tile per cycle while `i_sum_valid` is held.
- Last beat accepted at cycle t gives `o_res_valid`=1 at t+1, i.e. a latency of 1 cycle.
- Output handshake at cycle u gives IDLE at u+1, so the earliest next start is accepted at u+1 and the earliest next beat at u+2.
- All outputs are registered except `o_sum_ready`, which is decoded from the state register. There is no combinational path from any input to any output.

## Configuration
- `NFU2_ACC_SAT_EN` defined: each lane add saturates to the signed N-bit range, [-2^(N-1), 2^(N-1)-1]. Saturation is applied at every beat.
- `NFU2_ACC_SAT_EN` undefined: each lane add wraps modulo 2^N.

## Test plan
- Three tiles (`i_num_tiles`=3), every lane fed 1, then 2, then 3 on consecutive cycles -> every lane of `o_res` = 6. `o_res_valid` rises one cycle after the third beat and `o_tile_idx` steps 0,1,2.
- `i_num_tiles`=0 with a single beat where lane j = j -> lane j of `o_res` = j. The group completes after exactly one beat.
- Backpressure: in OUT, hold `i_res_ready`=0 for 5 cycles while `i_sum_valid`=1 -> `o_res` stays stable, `o_sum_ready`=0, and no beat is absorbed. Raising `i_res_ready` returns the block to IDLE on the next cycle.
- Overflow, two tiles with all lanes 16'h7000 -> 16'hE000 without the macro, 16'h7FFF with it. Two tiles with all lanes 16'h9000 -> 16'h2000 without the macro, 16'h8000 with it.
- Reset and abort mid-group, `i_num_tiles`=4:
  - Drop `rst_n` after 2 beats -> all outputs 0 immediately.
  - Pulse `i_clear` after 2 beats -> IDLE next cycle.
  - In both cases, a fresh 1-tile group with lanes 5 yields 5, with no carry-over.
- `i_start` pulsed during ACCUM with `i_num_tiles`=9 -> ignored. The group completes with the originally latched count.
